sa_result_drain: RTL and testbench

- Downstream stage of SA_CORE: consumes the per-row result ports (routport data, rvalidport flags) and serializes them into a single ready/valid stream for writeback.
- Captures a snapshot of all valid rows, then acknowledges the core with a one-cycle outread pulse.
- Pushes the captured rows, lowest index first, into an output FIFO that is first-word-fall-through.
- Tags each word with its row index and marks the last word of each snapshot.

---
 rtl/sa_result_drain.sv | 167 ++++++++++++++++
 tb/tb_sa_result_drain.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots SA_CORE per-row results and serializes them
// lowest row first into a first-word-fall-through ready/valid FIFO.
module sa_result_drain #(
  parameter int ROWS  = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  rvalid_in,
  input  logic [ROWS*DW-1:0] rdata_in,
  output logic             outread,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [RW-1:0]    m_row,
  output logic             m_last,
  output logic             busy,
  output logic [CW-1:0]    fifo_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SERIALIZE
  } state_t;

  localparam logic [ROWS-1:0] ONE   = ROWS'(1);
  localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
  localparam logic [AW-1:0]   PINC  = AW'(1);
  localparam logic [CW-1:0]   CINC  = CW'(1);

  state_t state_q, state_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic [DW-1:0] hold_q [ROWS];
  logic [DW-1:0] hold_d [ROWS];
  logic outread_q, outread_d;
  logic busy_q, busy_d;

  logic [DW-1:0] mem_data_q [DEPTH];
  logic [RW-1:0] mem_row_q  [DEPTH];
  logic          mem_last_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [RW-1:0]   sel_row;
  logic [ROWS-1:0] sel_bit;
  logic            sel_last;
  logic            draining;
  logic            pop;
  logic            can_push;
  logic            push;

  // Pick the lowest pending row and flag it as last when it is the only one left.
  always_comb begin
    sel_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (mask_q[r]) begin
        sel_row = RW'(r);
      end
    end
    sel_bit  = mask_q & (~mask_q + ONE);
    sel_last = (mask_q & (mask_q - ONE)) == '0;
  end

  // Push/pop qualification; a full FIFO still takes a push when it pops.
  always_comb begin
    draining = (state_q == ACK) || (state_q == SERIALIZE);
    pop      = (count_q != '0) && m_ready;
    can_push = (count_q < FULL) || pop;
    push     = draining && (mask_q != '0) && can_push;
  end

  // Snapshot capture and serialization sequencing.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (rvalid_in != '0) begin
          mask_d = rvalid_in;
          for (int r = 0; r < ROWS; r++) begin
            hold_d[r] = rdata_in[r*DW +: DW];
          end
          state_d = ACK;
        end
      end
      ACK, SERIALIZE: begin
        state_d = SERIALIZE;
        if (push) begin
          mask_d = mask_q & ~sel_bit;
          if (sel_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    outread_d = (state_d == ACK);
    busy_d    = (state_d != IDLE);
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PINC : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PINC : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CINC;
      2'b01:   count_d = count_q - CINC;
      default: count_d = count_q;
    endcase
  end

  // Control state, snapshot registers and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      outread_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        hold_q[r] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      outread_q <= outread_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
    end
  end

  // FIFO storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= hold_q[sel_row];
      mem_row_q[wr_ptr_q]  <= sel_row;
      mem_last_q[wr_ptr_q] <= sel_last;
    end
  end

  // Head of the FIFO falls through; outputs read zero while empty.
  always_comb begin
    m_valid    = (count_q != '0);
    m_data     = m_valid ? mem_data_q[rd_ptr_q] : '0;
    m_row      = m_valid ? mem_row_q[rd_ptr_q]  : '0;
    m_last     = m_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    outread    = outread_q;
    busy       = busy_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: directed checks of snapshot capture, ordering,
// backpressure, full push/pop, back-to-back snapshots and async reset.
module tb_sa_result_drain;

  localparam int ROWS  = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  row;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } word_t;

  logic clk = 0;
  logic rst;
  logic [ROWS-1:0] rvalid_in;
  logic [ROWS*DW-1:0] rdata_in;
  logic outread;
  logic m_valid;
  logic m_ready;
  logic [DW-1:0] m_data;
  logic [2:0] m_row;
  logic m_last;
  logic busy;
  logic [3:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int orc     = 0;
  int lc      = 0;
  word_t pops[$];
  word_t exp_q[$];

  sa_result_drain #(
    .ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .rvalid_in(rvalid_in), .rdata_in(rdata_in),
    .outread(outread),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_row(m_row), .m_last(m_last),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Record accepted words and acknowledge pulses away from the edge.
  always @(negedge clk) begin
    cyc++;
    if (m_valid && m_ready) begin
      word_t w;
      w.row = m_row;
      w.data = m_data;
      w.last = m_last;
      w.cyc = cyc;
      pops.push_back(w);
      if (m_last) lc++;
    end
    if (outread) orc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [ROWS-1:0] v, input int base);
    rvalid_in = v;
    for (int r = 0; r < ROWS; r++) rdata_in[r*DW +: DW] = DW'(base + r);
  endtask

  task automatic expect_word(input int row, input int data, input bit last);
    word_t w;
    w.row = 3'(row);
    w.data = 32'(data);
    w.last = last;
    w.cyc = 0;
    exp_q.push_back(w);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((busy || fifo_count != 0) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(busy || fifo_count != 0), 0);
  endtask

  task automatic cmp_words(input string tag);
    int n;
    chk({tag, "_count"}, pops.size(), exp_q.size());
    n = (pops.size() < exp_q.size()) ? pops.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_row%0d", tag, i), 32'(pops[i].row), 32'(exp_q[i].row));
      chk($sformatf("%s_data%0d", tag, i), pops[i].data, exp_q[i].data);
      chk($sformatf("%s_last%0d", tag, i), 32'(pops[i].last), 32'(exp_q[i].last));
    end
  endtask

  task automatic clear_log();
    pops.delete();
    exp_q.delete();
    orc = 0;
    lc = 0;
  endtask

  initial begin
    int n;
    rst = 1;
    m_ready = 0;
    rvalid_in = '0;
    rdata_in = '0;
    tick();
    tick();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_outread", 32'(outread), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", m_data, 0);
    rst = 0;
    tick();

    // Full snapshot, streaming
    clear_log();
    m_ready = 1;
    set_rows(8'hFF, 100);
    chk("full_pre_outread", 32'(outread), 0);
    tick();
    chk("full_outread", 32'(outread), 1);
    chk("full_busy", 32'(busy), 1);
    rvalid_in = '0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("full_busy_cycles", n, 8);
    drain(50);
    for (int r = 0; r < 8; r++) expect_word(r, 100 + r, r == 7);
    cmp_words("full");
    chk("full_outread_cnt", orc, 1);
    if (pops.size() == 8)
      chk("full_consecutive", pops[7].cyc - pops[0].cyc, 7);
    else
      chk("full_consecutive", pops.size(), 8);

    // Sparse mask
    clear_log();
    set_rows(8'b1010_0100, 'hA0);
    tick();
    rvalid_in = '0;
    drain(50);
    expect_word(2, 'hA2, 0);
    expect_word(5, 'hA5, 0);
    expect_word(7, 'hA7, 1);
    cmp_words("sparse");
    chk("sparse_outread_cnt", orc, 1);

    // Backpressure until full, then a single push/pop at full
    clear_log();
    m_ready = 0;
    set_rows(8'hFF, 200);
    tick();
    rvalid_in = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_mask_left", $countones(dut.mask_q), 4);
    chk("bp_head_data", m_data, 200);
    chk("bp_head_row", 32'(m_row), 0);
    tick();
    tick();
    chk("bp_head_stable", m_data, 200);
    chk("bp_outread_cnt", orc, 1);
    m_ready = 1;
    tick();
    m_ready = 0;
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_head_data", m_data, 201);
    chk("pp_mask_left", $countones(dut.mask_q), 3);
    chk("pp_pops", pops.size(), 1);
    tick();
    m_ready = 1;
    drain(50);
    for (int r = 0; r < 8; r++) expect_word(r, 200 + r, r == 7);
    cmp_words("bp");

    // Back-to-back snapshots with rvalid held high
    clear_log();
    for (int i = 0; i < 12; i++) begin
      set_rows(8'h03, i << 4);
      tick();
    end
    rvalid_in = '0;
    drain(50);
    chk("b2b_outread_cnt", orc, 4);
    chk("b2b_last_cnt", lc, orc);
    expect_word(0, 'h00, 0);
    expect_word(1, 'h01, 1);
    expect_word(0, 'h30, 0);
    expect_word(1, 'h31, 1);
    expect_word(0, 'h60, 0);
    expect_word(1, 'h61, 1);
    expect_word(0, 'h90, 0);
    expect_word(1, 'h91, 1);
    cmp_words("b2b");

    // Reset in the middle of serialization
    clear_log();
    m_ready = 0;
    set_rows(8'hFF, 300);
    tick();
    rvalid_in = '0;
    tick();
    tick();
    tick();
    chk("mid_count", 32'(fifo_count), 3);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_outread", 32'(outread), 0);
    chk("mid_rst_data", m_data, 0);
    tick();
    rst = 0;
    tick();
    clear_log();
    m_ready = 1;
    set_rows(8'b0011_0000, 400);
    tick();
    rvalid_in = '0;
    drain(50);
    expect_word(4, 404, 0);
    expect_word(5, 405, 1);
    cmp_words("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
